agc_monitor_step_ctrl: RTL and testbench
========================================

# agc_monitor_step_ctrl

Monitor-side controller for the AGC timer's stop/step interface. It drives the monitor stop level MSTP and the monitor start pulse MSTRTP into the timer module, and watches MT01..MT12, MSTPIT_ and MGOJAM coming back. Host commands let a test bench or monitor run the AGC freely, halt it at the end of a memory cycle (MCT), or single-step N MCTs. The block also keeps an MCT count and records the most recent timepulse seen.

## Interface
- STRT_WIDTH, 2, width of each MSTRTP pulse in CLOCK cycles (1..15).
- TIMEOUT, 1024, maximum CLOCK cycles to wait for any acknowledge before declaring a fault (≥16).

- CLOCK  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- MT  in  12  monitor timepulses, one-hot; bit i-1 = MTi.
- MSTPIT_  in  1  low while the timer is held stopped by MSTP.
- MGOJAM  in  1  monitor copy of GOJAM (restart), active high.
- cmd_run, cmd_stop, cmd_step  in  1 each  single-cycle host command strobes.
- step_cnt  in  8  number of MCTs to step; sampled with cmd_step.
- MSTP  out  1  stop request level to the timer.
- MSTRTP  out  1  start/advance pulse to the timer.
- stopped  out  1  high in STOPPED.
- busy  out  1  high in STOPPING or STEPPING.
- fault  out  1  sticky acknowledge-timeout flag.
- mct_count  out  16  count of MT01 rising edges.
- last_tp  out  4  number (1..12) of the last valid timepulse; 0 after reset.
- steps_left  out  8  MCTs still to be stepped.

## Operation
- States: RUN, STOPPING, STOPPED, STEP_PULSE, STEP_WAIT_START, STEP_WAIT_STOP, FAULT.
- Reset: state RUN. All outputs are 0: MSTP, MSTRTP, stopped, busy, fault, mct_count, last_tp and steps_left.
- If commands arrive together, priority is cmd_stop > cmd_step > cmd_run. Any command invalid for the current state is ignored.

**State behaviour**
- RUN: MSTP=0. cmd_stop goes to STOPPING. cmd_step and cmd_run are ignored.
- STOPPING: MSTP=1. MSTPIT_=0 goes to STOPPED.
- STOPPED: MSTP=1.
  - cmd_run goes to RUN.
  - cmd_step with step_cnt≠0 loads steps_left and goes to STEP_PULSE.
  - cmd_step with step_cnt=0 is ignored.
- STEP_PULSE: MSTRTP=1 for STRT_WIDTH cycles, then go to STEP_WAIT_START.
- STEP_WAIT_START: wait for an MT01 rising edge, then go to STEP_WAIT_STOP.
- STEP_WAIT_STOP: wait for MSTPIT_=0, then decrement steps_left.
  - If steps_left reaches 0, go to STOPPED.
  - Otherwise go to STEP_PULSE.
- cmd_stop in any STEP_* state clears steps_left. The current MCT completes through the normal wait path, and the block then enters STOPPED.
- FAULT: MSTP=1, fault=1. cmd_run goes to RUN and cmd_stop goes to STOPPING; both clear fault. fault is set only on entry to FAULT.

**Timeout**
- A wait counter clears on entry to STOPPING, STEP_WAIT_START and STEP_WAIT_STOP.
- If TIMEOUT cycles pass in one of these states without its exit condition, go to FAULT.

**MGOJAM**
- While MGOJAM=1 the block clears mct_count and steps_left.
- Any STEP_* state goes to STOPPING. RUN, STOPPED and FAULT are unchanged.

**Monitoring**
- An MT01 rising edge is MT[0] now 1, previous cycle 0. On each such edge mct_count increments, wrapping from 0xFFFF to 0.
- last_tp updates only when exactly one bit of MT is set. All-zero or multi-hot MT holds last_tp.

## Timing
- Every output is a flop output.
- MSTP rises the cycle after cmd_stop is sampled, and falls the cycle after cmd_run is sampled.
- stopped rises the cycle after MSTPIT_=0 is sampled in STOPPING.
- The first MSTRTP rises the cycle after cmd_step. Between successive steps MSTRTP stays low for at least 2 cycles.
- mct_count and last_tp update 1 cycle after the corresponding MT sample.
- busy = STOPPING or any STEP_* state.
- MSTRTP is 0 in every state other than STEP_PULSE.
- Reset mid-pulse drops MSTRTP and MSTP in the same instant, because reset is asynchronous.

## Test plan
- Reset, then drive MT01 rising 5 times with MT cycling 1..12 → mct_count=5, last_tp=12, MSTP=0, stopped=0.
- cmd_stop, then MSTPIT_ low 3 cycles later → MSTP=1 next cycle, busy=1, stopped=1 one cycle after MSTPIT_ sampled low.
- From STOPPED, cmd_step with step_cnt=3, with the model raising MSTPIT_ and MT01 after each MSTRTP and then lowering MSTPIT_ → exactly 3 MSTRTP pulses of 2 cycles each, steps_left 3→2→1→0, end in STOPPED, mct_count +3.
- cmd_step with step_cnt=2, MSTPIT_ held high and no MT01 after the first pulse → FAULT after TIMEOUT cycles, fault=1, MSTP=1; cmd_run → fault=0, MSTP=0.
- MGOJAM pulsed during STEP_WAIT_START with steps_left=4 → steps_left=0, mct_count=0, state STOPPING; MSTPIT_ low → stopped=1.
- Same-cycle cmd_stop + cmd_run in RUN → MSTP=1 (stop wins). MT=0x003 (multi-hot) → last_tp unchanged.

Source files
------------

// File: rtl/agc_monitor_step_ctrl_if.sv
// Host/timer-facing signal bundle for the AGC monitor stop/step controller.
// The slave side is the controller itself; the master side is whatever drives it.
interface agc_monitor_step_ctrl_if;
  logic [11:0] MT;
  logic        MSTPIT_;
  logic        MGOJAM;
  logic        cmd_run;
  logic        cmd_stop;
  logic        cmd_step;
  logic [7:0]  step_cnt;
  logic        MSTP;
  logic        MSTRTP;
  logic        stopped;
  logic        busy;
  logic        fault;
  logic [15:0] mct_count;
  logic [3:0]  last_tp;
  logic [7:0]  steps_left;

  modport master (
    output MT, MSTPIT_, MGOJAM, cmd_run, cmd_stop, cmd_step, step_cnt,
    input  MSTP, MSTRTP, stopped, busy, fault, mct_count, last_tp, steps_left
  );

  modport slave (
    input  MT, MSTPIT_, MGOJAM, cmd_run, cmd_stop, cmd_step, step_cnt,
    output MSTP, MSTRTP, stopped, busy, fault, mct_count, last_tp, steps_left
  );
endinterface

// File: rtl/agc_monitor_step_ctrl.sv
// Monitor-side stop/step controller for the AGC timer: drives MSTP/MSTRTP,
// single-steps memory cycles, and tracks MCT count and last timepulse.
module agc_monitor_step_ctrl #(
  parameter int STRT_WIDTH = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      CLOCK,
  input  logic                      rst,
  agc_monitor_step_ctrl_if.slave    bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    RUN, STOPPING, STOPPED, STEP_PULSE, STEP_WAIT_START, STEP_WAIT_STOP, FAULT
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait_cnt;
  logic [7:0]    r_steps_left, w_steps_next;
  logic          r_mt01_d;
  logic          r_mstp, r_mstrtp, r_stopped, r_busy, r_fault;
  logic [15:0]   r_mct_count;
  logic [3:0]    r_last_tp, w_tp_num;
  logic          w_mt01_rise, w_tmo, w_pulse_done, w_in_step;

  assign w_mt01_rise  = bus.MT[0] & ~r_mt01_d;
  // One counter serves both the pulse width and the acknowledge timeout.
  assign w_tmo        = (r_wait_cnt == CW'(TIMEOUT - 1));
  assign w_pulse_done = (r_wait_cnt == CW'(STRT_WIDTH - 1));
  assign w_in_step    = r_state inside {STEP_PULSE, STEP_WAIT_START, STEP_WAIT_STOP};

  always_comb begin
    w_tp_num = '0;
    for (int i = 0; i < 12; i++)
      if (bus.MT[i]) w_tp_num = 4'(i + 1);
  end

  always_comb begin
    w_next       = r_state;
    w_steps_next = r_steps_left;
    case (r_state)
      RUN:      if (bus.cmd_stop) w_next = STOPPING;
      STOPPING: if (!bus.MSTPIT_) w_next = STOPPED;
                else if (w_tmo)   w_next = FAULT;
      STOPPED: begin
        if (bus.cmd_stop) w_next = STOPPED;
        else if (bus.cmd_step && bus.step_cnt != 8'd0) begin
          w_next       = STEP_PULSE;
          w_steps_next = bus.step_cnt;
        end else if (bus.cmd_run) w_next = RUN;
      end
      STEP_PULSE: begin
        if (bus.cmd_stop) w_steps_next = '0;
        if (w_pulse_done) w_next = STEP_WAIT_START;
      end
      STEP_WAIT_START: begin
        if (bus.cmd_stop) w_steps_next = '0;
        if (w_mt01_rise) w_next = STEP_WAIT_STOP;
        else if (w_tmo)  w_next = FAULT;
      end
      STEP_WAIT_STOP: begin
        if (!bus.MSTPIT_) begin
          // A stop request already zeroed the remaining count, so it lands in STOPPED.
          if (bus.cmd_stop || r_steps_left <= 8'd1) begin
            w_next       = STOPPED;
            w_steps_next = '0;
          end else begin
            w_next       = STEP_PULSE;
            w_steps_next = r_steps_left - 8'd1;
          end
        end else begin
          if (bus.cmd_stop) w_steps_next = '0;
          if (w_tmo) w_next = FAULT;
        end
      end
      FAULT: if (bus.cmd_stop)     w_next = STOPPING;
             else if (bus.cmd_run) w_next = RUN;
      default: w_next = RUN;
    endcase
    if (bus.MGOJAM) begin
      w_steps_next = '0;
      if (w_in_step) w_next = STOPPING;
      else if (w_next inside {STEP_PULSE, STEP_WAIT_START, STEP_WAIT_STOP}) w_next = r_state;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_steps_left <= '0;
      r_mt01_d     <= 1'b0;
      r_mct_count  <= '0;
      r_last_tp    <= '0;
      r_mstp       <= 1'b0;
      r_mstrtp     <= 1'b0;
      r_stopped    <= 1'b0;
      r_busy       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_steps_left <= w_steps_next;
      r_wait_cnt   <= (w_next != r_state) ? '0 : r_wait_cnt + CW'(1);
      r_mt01_d     <= bus.MT[0];
      if (bus.MGOJAM)       r_mct_count <= '0;
      else if (w_mt01_rise) r_mct_count <= r_mct_count + 16'd1;
      if ($onehot(bus.MT))  r_last_tp <= w_tp_num;
      // Outputs decode the next state so they are flops aligned with r_state.
      r_mstp    <= (w_next != RUN);
      r_mstrtp  <= (w_next == STEP_PULSE);
      r_stopped <= (w_next == STOPPED);
      r_busy    <= w_next inside {STOPPING, STEP_PULSE, STEP_WAIT_START, STEP_WAIT_STOP};
      r_fault   <= (w_next == FAULT);
    end
  end

  assign bus.MSTP       = r_mstp;
  assign bus.MSTRTP     = r_mstrtp;
  assign bus.stopped    = r_stopped;
  assign bus.busy       = r_busy;
  assign bus.fault      = r_fault;
  assign bus.mct_count  = r_mct_count;
  assign bus.last_tp    = r_last_tp;
  assign bus.steps_left = r_steps_left;
endmodule

// File: tb/tb_agc_monitor_step_ctrl.sv
// Directed + randomized bench for agc_monitor_step_ctrl with a behavioural
// timepulse/MCT model and an MSTRTP pulse-shape tracker.
module tb_agc_monitor_step_ctrl;
  localparam int SW = 2;
  localparam int TO = 64;

  logic CLOCK = 1'b0;
  logic rst   = 1'b1;

  agc_monitor_step_ctrl_if bus();
  agc_monitor_step_ctrl #(.STRT_WIDTH(SW), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .rst(rst), .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int m_mct  = 0;
  int m_tp   = 0;
  bit m_prev0 = 1'b0;
  int hi_len = 0;
  int gap    = 0;
  int pulses = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the reference model from inputs seen at the edge, then
  // observe MSTRTP pulse shape 1 time unit later.
  task automatic cyc();
    @(posedge CLOCK);
    if (rst) begin
      m_mct = 0; m_tp = 0; m_prev0 = 1'b0;
    end else begin
      if (bus.MGOJAM) m_mct = 0;
      else if (bus.MT[0] && !m_prev0) m_mct = (m_mct + 1) % 65536;
      if ($countones(bus.MT) == 1) m_tp = $clog2(bus.MT) + 1;
      m_prev0 = bus.MT[0];
    end
    #1;
    if (bus.MSTRTP) begin
      if (hi_len == 0) begin
        pulses++;
        if (pulses > 1) chk("strtp_gap_ge2", 32'(gap >= 2), 1);
      end
      hi_len++;
      gap = 0;
    end else begin
      if (hi_len != 0) chk("strtp_width", hi_len, SW);
      hi_len = 0;
      gap++;
    end
  endtask

  task automatic wait_strtp(logic lvl, string tag);
    int n = 0;
    while (bus.MSTRTP !== lvl && n < 50) begin cyc(); n++; end
    chk(tag, bus.MSTRTP, lvl);
  endtask

  task automatic run_steps(int n);
    int p0 = pulses;
    int c0 = m_mct;
    bus.step_cnt = 8'(n); bus.cmd_step = 1'b1; cyc(); bus.cmd_step = 1'b0;
    chk("step_first_strtp", bus.MSTRTP, 1);
    chk("step_load", bus.steps_left, n);
    for (int k = 1; k <= n; k++) begin
      wait_strtp(1'b1, "strtp_rise");
      wait_strtp(1'b0, "strtp_fall");
      bus.MSTPIT_ = 1'b1; repeat ($urandom_range(0, 3)) cyc();
      bus.MT = 12'h001; cyc(); bus.MT = 12'h000;
      repeat ($urandom_range(0, 3)) cyc();
      bus.MSTPIT_ = 1'b0; cyc();
      chk("steps_left", bus.steps_left, n - k);
    end
    chk("step_pulses", pulses - p0, n);
    chk("step_mct_delta", m_mct - c0, n);
    chk("step_mct", bus.mct_count, m_mct);
    chk("step_end_stopped", bus.stopped, 1);
    chk("step_end_busy", bus.busy, 0);
    chk("step_end_mstp", bus.MSTP, 1);
  endtask

  initial begin
    int n;
    logic [3:0] tp0;
    bus.MT = '0; bus.MSTPIT_ = 1'b1; bus.MGOJAM = 1'b0;
    bus.cmd_run = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_step = 1'b0; bus.step_cnt = '0;
    #1;
    chk("rst_mstp", bus.MSTP, 0);       chk("rst_mstrtp", bus.MSTRTP, 0);
    chk("rst_stopped", bus.stopped, 0); chk("rst_busy", bus.busy, 0);
    chk("rst_fault", bus.fault, 0);     chk("rst_mct", bus.mct_count, 0);
    chk("rst_tp", bus.last_tp, 0);      chk("rst_steps", bus.steps_left, 0);
    repeat (2) cyc();
    rst = 1'b0;

    // Free-running monitoring: five MCTs of MT01..MT12.
    for (int k = 0; k < 60; k++) begin bus.MT = 12'(1 << (k % 12)); cyc(); end
    chk("mon_mct5", bus.mct_count, 5); chk("mon_tp12", bus.last_tp, 12);
    chk("mon_mct_model", bus.mct_count, m_mct);
    chk("mon_mstp", bus.MSTP, 0); chk("mon_stopped", bus.stopped, 0);
    bus.MT = '0; cyc();
    repeat (40) begin
      case ($urandom_range(0, 3))
        0:       bus.MT = '0;
        3:       bus.MT = 12'($urandom);
        default: bus.MT = 12'(1 << $urandom_range(0, 11));
      endcase
      cyc();
      chk("rnd_mct", bus.mct_count, m_mct);
      chk("rnd_tp", bus.last_tp, m_tp);
    end
    bus.MT = 12'h004; cyc(); bus.MT = '0; cyc();
    tp0 = bus.last_tp;
    chk("pre_multihot_tp3", tp0, 3);
    bus.MT = 12'h003; cyc();
    chk("multihot_tp_hold", bus.last_tp, 3);
    bus.MT = '0; cyc();

    // Stop at end of MCT.
    bus.cmd_stop = 1'b1; cyc(); bus.cmd_stop = 1'b0;
    chk("stop_mstp", bus.MSTP, 1); chk("stop_busy", bus.busy, 1); chk("stop_not_yet", bus.stopped, 0);
    repeat (2) cyc();
    bus.MSTPIT_ = 1'b0; cyc();
    chk("stopped", bus.stopped, 1); chk("stopped_busy", bus.busy, 0); chk("stopped_mstp", bus.MSTP, 1);

    // Zero-count step is ignored.
    bus.step_cnt = 8'd0; bus.cmd_step = 1'b1; cyc(); bus.cmd_step = 1'b0;
    chk("step0_stopped", bus.stopped, 1); chk("step0_strtp", bus.MSTRTP, 0);

    run_steps(3);
    repeat (3) run_steps($urandom_range(1, 4));

    // Acknowledge timeout.
    bus.MSTPIT_ = 1'b1;
    bus.step_cnt = 8'd2; bus.cmd_step = 1'b1; cyc(); bus.cmd_step = 1'b0;
    wait_strtp(1'b0, "to_strtp_fall");
    n = 0;
    while (bus.fault !== 1'b1 && n < TO + 10) begin cyc(); n++; end
    chk("fault_latency", n, TO);
    chk("fault_flag", bus.fault, 1); chk("fault_mstp", bus.MSTP, 1);
    chk("fault_busy", bus.busy, 0);  chk("fault_strtp", bus.MSTRTP, 0);
    bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0;
    chk("fault_clr", bus.fault, 0); chk("run_mstp", bus.MSTP, 0);

    // MGOJAM while waiting for the MCT to start.
    bus.cmd_stop = 1'b1; cyc(); bus.cmd_stop = 1'b0;
    bus.MSTPIT_ = 1'b0; cyc();
    chk("gj_pre_stopped", bus.stopped, 1);
    chk("gj_pre_mct_nz", 32'(bus.mct_count != 0), 1);
    bus.MSTPIT_ = 1'b1;
    bus.step_cnt = 8'd4; bus.cmd_step = 1'b1; cyc(); bus.cmd_step = 1'b0;
    wait_strtp(1'b0, "gj_strtp_fall");
    chk("gj_pre_steps", bus.steps_left, 4);
    bus.MGOJAM = 1'b1; cyc(); bus.MGOJAM = 1'b0;
    chk("gj_steps", bus.steps_left, 0); chk("gj_mct", bus.mct_count, 0);
    chk("gj_mct_model", bus.mct_count, m_mct);
    chk("gj_busy", bus.busy, 1); chk("gj_stopped", bus.stopped, 0); chk("gj_mstp", bus.MSTP, 1);
    bus.MSTPIT_ = 1'b0; cyc();
    chk("gj_stopped_after", bus.stopped, 1);

    // Simultaneous stop and run in RUN: stop wins.
    bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0;
    chk("run_again_mstp", bus.MSTP, 0);
    bus.cmd_stop = 1'b1; bus.cmd_run = 1'b1; cyc(); bus.cmd_stop = 1'b0; bus.cmd_run = 1'b0;
    chk("stop_wins_mstp", bus.MSTP, 1);
    cyc();
    chk("stop_wins_stopped", bus.stopped, 1);

    // Asynchronous reset in the middle of a start pulse.
    bus.step_cnt = 8'd1; bus.cmd_step = 1'b1; cyc(); bus.cmd_step = 1'b0;
    chk("mid_strtp", bus.MSTRTP, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_strtp", bus.MSTRTP, 0); chk("arst_mstp", bus.MSTP, 0);
    chk("arst_stopped", bus.stopped, 0); chk("arst_mct", bus.mct_count, 0);
    chk("arst_tp", bus.last_tp, 0);
    m_mct = 0; m_tp = 0; m_prev0 = 1'b0; hi_len = 0;
    cyc(); rst = 1'b0; cyc();
    chk("post_rst_steps", bus.steps_left, 0); chk("post_rst_mstp", bus.MSTP, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
